// File: rtl/mc_cpu_core_if.sv
// Shared instruction/data memory port of mc_cpu_core: req/ready handshake, one access in flight.
interface mc_cpu_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mc_cpu_core.sv
// Multicycle von Neumann CPU core: control FSM and datapath sharing one req/ready memory port.
module mc_cpu_core #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int REG_CNT = 16
) (
    input  logic          clk,
    input  logic          reset,
    mc_cpu_core_if.master bus,
    output logic          Halt,
    output logic          illegal,
    output logic [31:0]   instret
);
    localparam int RW = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, STOP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] gpr [REG_CNT];

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    logic [3:0]               op;
    logic [RW-1:0]            rd;
    logic [RW-1:0]            rs;
    logic [RW-1:0]            rt;
    logic [DATA_W-1:0]        alu_res;
    logic [ADDR_W-1:0]        eff_addr;
    logic signed [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0]        br_target;
    logic [ADDR_W-1:0]        jmp_target;

    // LD/ST fall through to the default arm, which forms the effective address.
    function automatic logic [DATA_W-1:0] alu(input logic [3:0] f,
                                              input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y,
                                              input logic [7:0] imm8);
        case (f)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_LDI:  return DATA_W'(imm8);
            default: return x + DATA_W'(imm8[3:0]);
        endcase
    endfunction

    assign op         = ir[15:12];
    assign rd         = ir[8 +: RW];
    assign rs         = ir[4 +: RW];
    assign rt         = ir[0 +: RW];
    assign alu_res    = alu(op, a, b, ir[7:0]);
    assign eff_addr   = ADDR_W'(alu_res);
    assign br_off     = ADDR_W'($signed(ir[3:0]));
    assign br_target  = pc + $unsigned(br_off);
    assign jmp_target = ADDR_W'(ir[11:0]);

    assign bus.mem_req   = req;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;

    // Every transition back into FETCH raises req with the next PC already on addr,
    // so the request is registered and nothing depends combinationally on mem_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < REG_CNT; i++) gpr[i] <= '0;
            req     <= 1'b0;
            we      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            Halt    <= 1'b0;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (!req) begin
                        req  <= 1'b1;
                        we   <= 1'b0;
                        addr <= pc;
                    end else if (bus.mem_ready) begin
                        ir    <= bus.mem_rdata[15:0];
                        pc    <= pc + ADDR_W'(1);
                        req   <= 1'b0;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a <= gpr[rs];
                    b <= (op == OP_ST || op == OP_BEQ) ? gpr[rd] : gpr[rt];
                    if (op == OP_HALT) begin
                        Halt  <= 1'b1;
                        state <= STOP;
                    end else if (op inside {[4'd11:4'd14]}) begin
                        Halt    <= 1'b1;
                        illegal <= 1'b1;
                        state   <= STOP;
                    end else if (op == OP_NOP) begin
                        req     <= 1'b1;
                        addr    <= pc;
                        instret <= instret + 32'd1;
                        state   <= FETCH;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    alu_out <= alu_res;
                    case (op)
                        OP_BEQ: begin
                            if (a == b) begin
                                pc   <= br_target;
                                addr <= br_target;
                            end else begin
                                addr <= pc;
                            end
                            req     <= 1'b1;
                            instret <= instret + 32'd1;
                            state   <= FETCH;
                        end
                        OP_JMP: begin
                            pc      <= jmp_target;
                            addr    <= jmp_target;
                            req     <= 1'b1;
                            instret <= instret + 32'd1;
                            state   <= FETCH;
                        end
                        OP_LD, OP_ST: begin
                            req   <= 1'b1;
                            we    <= (op == OP_ST);
                            addr  <= eff_addr;
                            wdata <= b;
                            state <= MEM;
                        end
                        default: state <= WB;
                    endcase
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        we <= 1'b0;
                        if (op == OP_LD) begin
                            mdr   <= bus.mem_rdata;
                            req   <= 1'b0;
                            state <= WB;
                        end else begin
                            addr    <= pc;
                            instret <= instret + 32'd1;
                            state   <= FETCH;
                        end
                    end
                end
                WB: begin
                    if (rd != '0) gpr[rd] <= (op == OP_LD) ? mdr : alu_out;
                    req     <= 1'b1;
                    addr    <= pc;
                    instret <= instret + 32'd1;
                    state   <= FETCH;
                end
                default: begin
                    state <= STOP;
                end
            endcase
        end
    end
endmodule

// File: doc/mc_cpu_core.md
# mc_cpu_core

Parametrised multicycle Von Neumann CPU core. It merges the control FSM and datapath into one block with configurable data width, register count and address width. Instructions and data share one memory port, and that port uses a req/ready handshake so the core tolerates variable-latency memory. The core also adds a retired-instruction counter and illegal-opcode detection. It is the top-level compute element that a testbench or SoC wrapper connects to a single memory model.

## Interface
- DATA_W, 16: register/ALU/memory word width (≥16); instruction = low 16 bits of fetched word
- ADDR_W, 12: word-address width of memory port and PC (≥8)
- REG_CNT, 16: number of GPRs (power of 2, 2..16); register fields use low log2(REG_CNT) bits
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; takes effect at the clk edge where sampled high
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  ADDR_W  word address; valid with mem_req
- mem_wdata  out  DATA_W  store data; valid with mem_req & mem_we
- mem_rdata  in  DATA_W  read data; sampled when mem_req & mem_ready & !mem_we
- mem_ready  in  1  completes the current access in the cycle it is high with mem_req
- Halt  out  1  core stopped (HALT or illegal opcode)
- illegal  out  1  stopped due to undefined opcode
- instret  out  32  count of retired instructions, wraps at 2^32

## Operation
- Instruction fields: op = [15:12], rd = [11:8], rs = [7:4], rt = [3:0], imm4 = [3:0], imm8 = [7:0], imm12 = [11:0].
- R0 reads as 0; writes to R0 are discarded.
- Opcodes:
  - 0 NOP
  - 1 ADD rd = rs+rt; 2 SUB rd = rs−rt; 3 AND; 4 OR; 5 XOR
  - 6 LDI rd = zext(imm8)
  - 7 LD rd = mem[rs+zext(imm4)]
  - 8 ST mem[rs+zext(imm4)] = rd
  - 9 BEQ: if rd==rs then PC = PC+1+sext(imm4)
  - 10 JMP: PC = zext(imm12), truncated to ADDR_W
  - 15 HALT
  - 11–14 illegal
- Arithmetic is modulo 2^DATA_W. Load/store addresses and branch targets are truncated to ADDR_W, with wrap-around.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, STOP.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ready, load IR ← rdata[15:0], set PC ← PC+1, go to DECODE.
  - DECODE: A ← R[rs], B ← R[rt or rd].
    - HALT → STOP with Halt=1.
    - Illegal → STOP with Halt=1 and illegal=1.
    - NOP → FETCH.
    - Otherwise → EXEC.
  - EXEC: ALUOut ← result or effective address.
    - BEQ/JMP update PC here and go to FETCH.
    - LD/ST → MEM.
    - ALU ops and LDI → WB.
  - MEM: hold mem_req, mem_addr and mem_we (plus mem_wdata for ST) stable until mem_ready.
    - LD: MDR ← rdata, go to WB.
    - ST → FETCH.
  - WB: R[rd] ← ALUOut, or MDR for LD; go to FETCH.
  - STOP: absorbing state; only reset exits it.
- instret increments by 1 on the final cycle of every completed instruction (NOP, ALU, LDI, LD, ST, BEQ, JMP). It does not increment for HALT or illegal opcodes.
- mem_req is low in every state other than FETCH and MEM.

## Timing
- Reset values:
  - State FETCH; PC, IR, A, B, ALUOut, MDR all 0; all GPRs 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, Halt=0, illegal=0, instret=0.
- First mem_req rises in the cycle after reset deasserts.
- Cycles per instruction with zero wait states (mem_ready high in the same cycle as mem_req):
  - NOP: 2
  - BEQ/JMP: 3
  - ALU/LDI/ST: 4
  - LD: 5
  - Each wait cycle (mem_ready low while mem_req is high) adds 1 cycle.
- Outputs are registered or state-decoded; there is no combinational path from mem_ready or mem_rdata to any output.
- Reset asserted mid-access: the pending request is abandoned. mem_req is 0 from the next edge and no register or memory side effect is completed.
- Halt asserts the cycle after DECODE of HALT or an illegal opcode, and stays high until reset.

## Test plan
- Zero-wait program `LDI R1,5; LDI R2,7; ADD R3,R1,R2; HALT`: R3=12; Halt high at cycle 15 after reset release; instret=3.
- Memory stalls mem_ready 3 cycles on every access, same program: R3=12; completion delayed by exactly 12 cycles; addr/we/wdata stable throughout each stall.
- `LDI R1,0x20; ST R1→[R0+4]; LD R4←[R0+4]; SUB R5,R4,R1; HALT`: mem[4]=0x20; R4=0x20; R5=0.
- Countdown loop decrementing R1 from 3 with `BEQ R1,R0,+1` and `JMP` back: loop exits after 3 iterations; instret matches the computed count; PC wraps correctly when the JMP target is ≥2^ADDR_W.
- Opcode 0xB fetched: Halt=1, illegal=1; instret unchanged; no further mem_req.
- Reset asserted while a ST is stalled in MEM: memory is never written; all outputs are at reset values on the next edge; execution refetches from address 0.
